// File: rtl/tl_pkg.sv
// Shared crossbar definitions: scheduler state encoding and TileLink opcodes.
package tl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  localparam int unsigned OPCODE_W = 3;

  // Channel A opcodes
  localparam logic [OPCODE_W-1:0] A_PUT_FULL_DATA    = 3'd0;
  localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [OPCODE_W-1:0] A_ARITHMETIC_DATA  = 3'd2;
  localparam logic [OPCODE_W-1:0] A_LOGICAL_DATA     = 3'd3;
  localparam logic [OPCODE_W-1:0] A_GET              = 3'd4;
  localparam logic [OPCODE_W-1:0] A_INTENT           = 3'd5;

  // Channel D opcodes
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA  = 3'd1;
  localparam logic [OPCODE_W-1:0] D_HINT_ACK         = 3'd2;

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping),
// skipping any requester set in excl.
module tl_rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found && req[cand] && !excl[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tl_req_scheduler.sv
// Channel A round-robin request scheduler with per-master in-flight limiting
// tracked through the Channel D response handshake.
module tl_req_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 3,
  parameter int unsigned SRC_WIDTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IDX_W           = $clog2(NUM_MASTERS),
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       a_valid,
  output logic [NUM_MASTERS-1:0]       a_ready,
  output logic                         a_valid_out,
  input  logic                         a_ready_out,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_active,
  input  logic                         d_valid_in,
  input  logic                         d_ready_in,
  input  logic [SRC_WIDTH-1:0]         d_source_in,
  output logic [NUM_MASTERS*CNT_W-1:0] outstanding,
  output logic                         err_underflow,
  output logic                         err_bad_source
);

  sched_state_e     state, state_n;
  logic [IDX_W-1:0] grant_idx_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] grant_next;

  logic [CNT_W-1:0] cnt [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] cnt_inc;
  logic [NUM_MASTERS-1:0] cnt_dec;
  logic                   a_hs;
  logic                   d_hs;
  logic                   src_bad;
  logic                   underflow;

  logic [IDX_W-1:0]       pick_ptr;
  logic [NUM_MASTERS-1:0] pick_excl;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;

  assign grant_next = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);

  assign grant_active = (state == GRANT);
  assign a_valid_out  = (state == GRANT) && a_valid[grant_idx];
  assign a_hs         = a_valid_out && a_ready_out;
  assign d_hs         = d_valid_in && d_ready_in;
  assign src_bad      = 32'(d_source_in) >= NUM_MASTERS;

  // Only the held master sees the downstream ready.
  always_comb begin
    a_ready = '0;
    if (state == GRANT) a_ready[grant_idx] = a_ready_out;
  end

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = a_valid[i] && (32'(cnt[i]) < MAX_OUTSTANDING);
    end
  end

  // On a handshake re-arbitrate from the advanced pointer, skipping the winner.
  always_comb begin
    pick_ptr  = rr_ptr;
    pick_excl = '0;
    if ((state == GRANT) && a_hs) begin
      pick_ptr             = grant_next;
      pick_excl[grant_idx] = 1'b1;
    end
  end

  tl_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (elig),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      rr_ptr    <= rr_ptr_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    rr_ptr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n     = GRANT;
          grant_idx_n = pick_idx;
        end
      end
      GRANT: begin
        if (a_hs) begin
          rr_ptr_n = grant_next;
          if (pick_found) grant_idx_n = pick_idx;
          else            state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-master increment/decrement requests; simultaneous ones cancel.
  always_comb begin
    cnt_inc   = '0;
    cnt_dec   = '0;
    underflow = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cnt_inc[i] = a_hs && (grant_idx == IDX_W'(i));
      cnt_dec[i] = d_hs && !src_bad && (d_source_in == SRC_WIDTH'(i));
      if (cnt_dec[i] && (cnt[i] == '0)) underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) cnt[i] <= '0;
      err_underflow  <= 1'b0;
      err_bad_source <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      if (underflow)        err_underflow  <= 1'b1;
      if (d_hs && src_bad)  err_bad_source <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_out
    assign outstanding[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_tl_req_scheduler.sv
// Directed bench for tl_req_scheduler: a vector table for the main arbitration
// flow plus hand-written limit, stall, error and reset sequences.
module tb_tl_req_scheduler;

  logic       clk;
  logic       reset;
  logic [2:0] a_valid;
  logic [2:0] a_ready;
  logic       a_valid_out;
  logic       a_ready_out;
  logic [1:0] grant_idx;
  logic       grant_active;
  logic       d_valid_in;
  logic       d_ready_in;
  logic [1:0] d_source_in;
  logic [5:0] outstanding;
  logic       err_underflow;
  logic       err_bad_source;

  int checks;
  int fails;

  tl_req_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_valid_out    (a_valid_out),
    .a_ready_out    (a_ready_out),
    .grant_idx      (grant_idx),
    .grant_active   (grant_active),
    .d_valid_in     (d_valid_in),
    .d_ready_in     (d_ready_in),
    .d_source_in    (d_source_in),
    .outstanding    (outstanding),
    .err_underflow  (err_underflow),
    .err_bad_source (err_bad_source)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] av;
    logic       aro;
    logic       dv;
    logic [1:0] src;
    logic [2:0] ex_ar;
    logic       ex_avo;
    logic [1:0] ex_gidx;
    logic       ex_gact;
    logic [5:0] ex_out;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    a_valid     = '0;
    a_ready_out = 1'b0;
    d_valid_in  = 1'b0;
    d_ready_in  = 1'b1;
    d_source_in = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;

    // Single request, then all three masters rotating, then a hold with deasserted valid.
    vecs[0]  = '{3'b010, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 1'b0, 6'b000000};
    vecs[1]  = '{3'b010, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 2'd1, 1'b1, 6'b000000};
    vecs[2]  = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd1, 1'b0, 6'b000100};
    vecs[3]  = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 2'd1, 1'b0, 6'b000100};
    vecs[4]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd1, 1'b0, 6'b000000};
    vecs[5]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b100, 1'b1, 2'd2, 1'b1, 6'b000000};
    vecs[6]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b001, 1'b1, 2'd0, 1'b1, 6'b010000};
    vecs[7]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b010, 1'b1, 2'd1, 1'b1, 6'b000001};
    vecs[8]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b100, 1'b1, 2'd2, 1'b1, 6'b000100};
    vecs[9]  = '{3'b000, 1'b1, 1'b1, 2'd2, 3'b001, 1'b0, 2'd0, 1'b1, 6'b010000};
    vecs[10] = '{3'b001, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 2'd0, 1'b1, 6'b000000};
    vecs[11] = '{3'b001, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 2'd0, 1'b1, 6'b000000};
    vecs[12] = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 1'b0, 6'b000001};

    do_reset();
    @(negedge clk);
    chk("rst_gact", 32'(grant_active), 0);
    chk("rst_gidx", 32'(grant_idx), 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_errs", 32'({err_underflow, err_bad_source}), 0);
    chk("rst_ar_avo", 32'({a_ready, a_valid_out}), 0);
    chk("rst_rr", 32'(dut.rr_ptr), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      a_valid     = vecs[i].av;
      a_ready_out = vecs[i].aro;
      d_valid_in  = vecs[i].dv;
      d_source_in = vecs[i].src;
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ex_ar));
      chk($sformatf("v%0d_a_valid_out", i), 32'(a_valid_out), 32'(vecs[i].ex_avo));
      chk($sformatf("v%0d_grant_idx", i), 32'(grant_idx), 32'(vecs[i].ex_gidx));
      chk($sformatf("v%0d_grant_active", i), 32'(grant_active), 32'(vecs[i].ex_gact));
      chk($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].ex_out));
      if (i == 2) chk("v2_rr_ptr", 32'(dut.rr_ptr), 2);
      @(posedge clk); #1;
    end
    d_valid_in = 1'b0;

    // In-flight limit on master 0 with no responses.
    do_reset();
    a_valid = 3'b001; a_ready_out = 1'b1;
    @(negedge clk); chk("lim_idle0", 32'(grant_active), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lim_g1_ready", 32'(a_ready), 32'(3'b001));
    @(posedge clk); #1;
    @(negedge clk); chk("lim_out1", 32'(outstanding), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("lim_g2_ready", 32'(a_ready), 32'(3'b001));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lim_blocked_ready", 32'(a_ready), 0);
      chk("lim_blocked_gact", 32'(grant_active), 0);
      chk("lim_blocked_out", 32'(outstanding), 2);
      @(posedge clk); #1;
    end
    d_valid_in = 1'b1; d_source_in = 2'd0;
    @(negedge clk); chk("lim_dret_gact", 32'(grant_active), 0);
    @(posedge clk); #1;
    d_valid_in = 1'b0;
    @(negedge clk);
    chk("lim_after_d_out", 32'(outstanding), 1);
    chk("lim_after_d_gact", 32'(grant_active), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lim_regrant_gact", 32'(grant_active), 1);
    chk("lim_regrant_ready", 32'(a_ready), 32'(3'b001));
    @(posedge clk); #1;

    // Downstream stall with masters 0 and 2 requesting.
    do_reset();
    a_valid = 3'b101; a_ready_out = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_gidx", 32'(grant_idx), 0);
      chk("stall_gact", 32'(grant_active), 1);
      chk("stall_ready", 32'(a_ready), 0);
      chk("stall_avo", 32'(a_valid_out), 1);
      @(posedge clk); #1;
    end
    a_ready_out = 1'b1;
    @(negedge clk); chk("stall_release_ready", 32'(a_ready), 32'(3'b001));
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_next_gidx", 32'(grant_idx), 2);
    chk("stall_next_ready", 32'(a_ready), 32'(3'b100));
    @(posedge clk); #1;

    // Error flags.
    do_reset();
    d_valid_in = 1'b1; d_source_in = 2'd1;
    @(posedge clk); #1;
    d_valid_in = 1'b0;
    @(negedge clk);
    chk("err_uf_flag", 32'(err_underflow), 1);
    chk("err_uf_bad", 32'(err_bad_source), 0);
    chk("err_uf_out", 32'(outstanding), 0);
    d_valid_in = 1'b1; d_ready_in = 1'b0; d_source_in = 2'd3;
    @(posedge clk); #1;
    @(negedge clk); chk("err_noready_bad", 32'(err_bad_source), 0);
    d_ready_in = 1'b1;
    @(posedge clk); #1;
    d_valid_in = 1'b0;
    @(negedge clk);
    chk("err_bad_flag", 32'(err_bad_source), 1);
    chk("err_uf_sticky", 32'(err_underflow), 1);
    chk("err_bad_out", 32'(outstanding), 0);

    // Reset while holding a grant with counts {1,2,0} and a flag set.
    do_reset();
    a_valid = 3'b010; a_ready_out = 1'b1; d_valid_in = 1'b1; d_source_in = 2'd3;
    cyc(1);
    d_valid_in = 1'b0;
    cyc(3);
    a_valid = 3'b001;
    cyc(2);
    a_ready_out = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("pre_rst_out", 32'(outstanding), 32'(6'b001001));
    chk("pre_rst_gact", 32'(grant_active), 1);
    chk("pre_rst_bad", 32'(err_bad_source), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; a_valid = '0;
    @(negedge clk);
    chk("mid_rst_out", 32'(outstanding), 0);
    chk("mid_rst_gact", 32'(grant_active), 0);
    chk("mid_rst_errs", 32'({err_underflow, err_bad_source}), 0);
    chk("mid_rst_gidx", 32'(grant_idx), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
